// File: rtl/lsu_mem_unit_if.sv
// Core request/response channel plus data-memory port of the load/store unit.
// The unit connects through the slave modport; the core/memory side uses master.
interface lsu_mem_unit_if #(
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [4:0]        req_rd;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [4:0]        resp_rd;
    logic [1:0]        resp_err;

    logic [DATA_W-1:0] addr_data;
    logic [DATA_W-1:0] data_out_data;
    logic [DATA_W-1:0] data_in_data;
    logic              en_data;
    logic [NB-1:0]     we_data;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_rd, resp_err,
        input  addr_data, data_out_data, en_data, we_data,
        output data_in_data
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_rdata, resp_rd, resp_err,
        output addr_data, data_out_data, en_data, we_data,
        input  data_in_data
    );
endinterface

// File: rtl/lsu_mem_unit.sv
// Load/store unit: decodes RV32I/RV64I access sizes, places bytes in little-endian
// lanes, flags misaligned/illegal requests and waits out the memory read latency.
module lsu_mem_unit #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic          aclk,
    input  logic          areset,
    lsu_mem_unit_if.slave bus
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [LB-1:0]     lane_q, lane_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic [1:0]        resp_err_q, resp_err_d;
    logic [DATA_W-1:0] addr_data_q, addr_data_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              en_data_q, en_data_d;
    logic [NB-1:0]     we_data_q, we_data_d;

    logic [LB-1:0]     req_lane_c;
    logic [LB+2:0]     req_shamt_c;
    logic              illegal_c;
    logic              misaligned_c;
    logic [NB-1:0]     size_mask_c;

    logic [LB+2:0]     ld_shamt_c;
    logic [DATA_W-1:0] ld_shift_c;
    logic [DATA_W-1:0] ld_data_c;

    // Incoming request decode: legality, alignment and store lane mask
    always_comb begin
        req_lane_c   = bus.req_addr[LB-1:0];
        req_shamt_c  = {req_lane_c, 3'b000};
        illegal_c    = (bus.req_funct3 == 3'd7) || (bus.req_store && bus.req_funct3[2]);
        if ((DATA_W == 32) && ((bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6))) begin
            illegal_c = 1'b1;
        end
        misaligned_c = 1'b0;
        size_mask_c  = '1;
        case (bus.req_funct3[1:0])
            2'd0: begin
                size_mask_c = NB'(1);
            end
            2'd1: begin
                misaligned_c = bus.req_addr[0];
                size_mask_c  = NB'(3);
            end
            2'd2: begin
                misaligned_c = |bus.req_addr[1:0];
                size_mask_c  = NB'(15);
            end
            default: begin
                misaligned_c = |bus.req_addr[2:0];
                size_mask_c  = '1;
            end
        endcase
    end

    // Load data: move the addressed lane down, then sign- or zero-extend
    always_comb begin
        ld_shamt_c = {lane_q, 3'b000};
        ld_shift_c = bus.data_in_data >> ld_shamt_c;
        case (funct3_q)
            3'd0:    ld_data_c = DATA_W'($signed(ld_shift_c[7:0]));
            3'd1:    ld_data_c = DATA_W'($signed(ld_shift_c[15:0]));
            3'd2:    ld_data_c = DATA_W'($signed(ld_shift_c[31:0]));
            3'd4:    ld_data_c = DATA_W'(ld_shift_c[7:0]);
            3'd5:    ld_data_c = DATA_W'(ld_shift_c[15:0]);
            3'd6:    ld_data_c = DATA_W'(ld_shift_c[31:0]);
            default: ld_data_c = ld_shift_c;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_rd_d    = '0;
        resp_err_d   = '0;
        addr_data_d  = '0;
        data_out_d   = '0;
        en_data_d    = 1'b0;
        we_data_d    = '0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    store_d     = bus.req_store;
                    funct3_d    = bus.req_funct3;
                    lane_d      = req_lane_c;
                    rd_d        = bus.req_rd;
                    if (illegal_c || misaligned_c) begin
                        // Illegal size wins; misaligned bit only reported for legal sizes
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rd_d    = bus.req_rd;
                        resp_err_d   = {illegal_c, misaligned_c & ~illegal_c};
                    end else begin
                        state_d     = ACCESS;
                        en_data_d   = 1'b1;
                        addr_data_d = {bus.req_addr[DATA_W-1:LB], LB'(0)};
                        if (bus.req_store) begin
                            we_data_d  = size_mask_c << req_lane_c;
                            data_out_d = bus.req_wdata << req_shamt_c;
                        end
                    end
                end
            end
            ACCESS: begin
                if (store_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data_c;
                    resp_rd_d    = rd_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            lane_q       <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= '0;
            addr_data_q  <= '0;
            data_out_q   <= '0;
            en_data_q    <= 1'b0;
            we_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            addr_data_q  <= addr_data_d;
            data_out_q   <= data_out_d;
            en_data_q    <= en_data_d;
            we_data_q    <= we_data_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.addr_data     = addr_data_q;
    assign bus.data_out_data = data_out_q;
    assign bus.en_data       = en_data_q;
    assign bus.we_data       = we_data_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit: a 32-bit (latency 2) and a 64-bit (latency 1)
// instance, each with a small byte-writable memory whose read data is valid one cycle only.
module tb_lsu_mem_unit;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    lsu_mem_unit_if #(.DATA_W(32)) if32 ();
    lsu_mem_unit_if #(.DATA_W(64)) if64 ();

    lsu_mem_unit #(.DATA_W(32), .MEM_LATENCY(2)) dut32 (.aclk(clk), .areset(areset), .bus(if32));
    lsu_mem_unit #(.DATA_W(64), .MEM_LATENCY(1)) dut64 (.aclk(clk), .areset(areset), .bus(if64));

    // 32-bit memory, two read stages; contents reload on reset
    logic [31:0] mem32 [16];
    logic [31:0] p32_d1, p32_d2;
    logic        p32_v1, p32_v2;
    always @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < 16; i++) mem32[i] <= (i == 0) ? 32'h8899AABB : 32'h0;
            p32_v1 <= 1'b0;
            p32_v2 <= 1'b0;
        end else begin
            p32_v1 <= if32.en_data && (if32.we_data == 4'h0);
            p32_d1 <= mem32[if32.addr_data[5:2]];
            p32_v2 <= p32_v1;
            p32_d2 <= p32_d1;
            if (if32.en_data)
                for (int b = 0; b < 4; b++)
                    if (if32.we_data[b]) mem32[if32.addr_data[5:2]][8*b +: 8] <= if32.data_out_data[8*b +: 8];
        end
    end
    assign if32.data_in_data = p32_v2 ? p32_d2 : 32'hDEADBEEF;

    // 64-bit memory, one read stage
    logic [63:0] mem64 [16];
    logic [63:0] p64_d1;
    logic        p64_v1;
    always @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < 16; i++) mem64[i] <= (i == 1) ? 64'h80000000_00000001 : 64'h0;
            p64_v1 <= 1'b0;
        end else begin
            p64_v1 <= if64.en_data && (if64.we_data == 8'h00);
            p64_d1 <= mem64[if64.addr_data[6:3]];
            if (if64.en_data)
                for (int b = 0; b < 8; b++)
                    if (if64.we_data[b]) mem64[if64.addr_data[6:3]][8*b +: 8] <= if64.data_out_data[8*b +: 8];
        end
    end
    assign if64.data_in_data = p64_v1 ? p64_d1 : 64'hDEADBEEF_DEADBEEF;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] r_rdy, r_en_cnt, r_en_cyc, r_addr, r_we, r_dout;
    logic [63:0] r_resp_cnt, r_resp_cyc, r_rdata, r_rd, r_err, r_leak;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and record what the unit does over the next 8 cycles
    task automatic txn(input bit w64, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
        logic        s_en, s_rv;
        logic [63:0] s_addr, s_we, s_dout, s_rdata, s_rd, s_err;
        @(negedge clk);
        if (w64) begin
            if64.req_store = st; if64.req_funct3 = f3; if64.req_addr = addr;
            if64.req_wdata = wdata; if64.req_rd = rd; if64.req_valid = 1'b1;
            r_rdy = 64'(if64.req_ready);
        end else begin
            if32.req_store = st; if32.req_funct3 = f3; if32.req_addr = addr[31:0];
            if32.req_wdata = wdata[31:0]; if32.req_rd = rd; if32.req_valid = 1'b1;
            r_rdy = 64'(if32.req_ready);
        end
        r_en_cnt = 0; r_en_cyc = 0; r_addr = 0; r_we = 0; r_dout = 0;
        r_resp_cnt = 0; r_resp_cyc = 0; r_rdata = 0; r_rd = 0; r_err = 0; r_leak = 0;
        @(posedge clk);
        @(negedge clk);
        if32.req_valid = 1'b0;
        if64.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (w64) begin
                s_en = if64.en_data; s_addr = if64.addr_data; s_we = 64'(if64.we_data);
                s_dout = if64.data_out_data; s_rv = if64.resp_valid; s_rdata = if64.resp_rdata;
                s_rd = 64'(if64.resp_rd); s_err = 64'(if64.resp_err);
            end else begin
                s_en = if32.en_data; s_addr = 64'(if32.addr_data); s_we = 64'(if32.we_data);
                s_dout = 64'(if32.data_out_data); s_rv = if32.resp_valid; s_rdata = 64'(if32.resp_rdata);
                s_rd = 64'(if32.resp_rd); s_err = 64'(if32.resp_err);
            end
            if (s_en) begin
                r_en_cnt = r_en_cnt + 1; r_en_cyc = 64'(c);
                r_addr = s_addr; r_we = s_we; r_dout = s_dout;
            end
            if (s_rv) begin
                r_resp_cnt = r_resp_cnt + 1; r_resp_cyc = 64'(c);
                r_rdata = s_rdata; r_rd = s_rd; r_err = s_err;
            end else if ((s_rdata != 0) || (s_rd != 0) || (s_err != 0)) begin
                r_leak = r_leak + 1;
            end
            if (c < 8) @(negedge clk);
        end
    endtask

    task automatic exp_load(input string tag, input logic [63:0] addr, input logic [63:0] rdata,
                            input logic [63:0] cyc, input logic [63:0] rd);
        chk({tag, ".ready"},    r_rdy, 1);
        chk({tag, ".en_cnt"},   r_en_cnt, 1);
        chk({tag, ".en_cyc"},   r_en_cyc, 1);
        chk({tag, ".addr"},     r_addr, addr);
        chk({tag, ".we"},       r_we, 0);
        chk({tag, ".resp_cnt"}, r_resp_cnt, 1);
        chk({tag, ".resp_cyc"}, r_resp_cyc, cyc);
        chk({tag, ".rdata"},    r_rdata, rdata);
        chk({tag, ".rd"},       r_rd, rd);
        chk({tag, ".err"},      r_err, 0);
        chk({tag, ".leak"},     r_leak, 0);
    endtask

    task automatic exp_store(input string tag, input logic [63:0] addr, input logic [63:0] we,
                             input logic [63:0] dout, input logic [63:0] rd);
        chk({tag, ".ready"},    r_rdy, 1);
        chk({tag, ".en_cnt"},   r_en_cnt, 1);
        chk({tag, ".en_cyc"},   r_en_cyc, 1);
        chk({tag, ".addr"},     r_addr, addr);
        chk({tag, ".we"},       r_we, we);
        chk({tag, ".dout"},     r_dout, dout);
        chk({tag, ".resp_cnt"}, r_resp_cnt, 1);
        chk({tag, ".resp_cyc"}, r_resp_cyc, 2);
        chk({tag, ".rdata"},    r_rdata, 0);
        chk({tag, ".rd"},       r_rd, rd);
        chk({tag, ".err"},      r_err, 0);
        chk({tag, ".leak"},     r_leak, 0);
    endtask

    task automatic exp_err(input string tag, input logic [63:0] err, input logic [63:0] rd);
        chk({tag, ".ready"},    r_rdy, 1);
        chk({tag, ".en_cnt"},   r_en_cnt, 0);
        chk({tag, ".resp_cnt"}, r_resp_cnt, 1);
        chk({tag, ".resp_cyc"}, r_resp_cyc, 1);
        chk({tag, ".err"},      r_err, err);
        chk({tag, ".rdata"},    r_rdata, 0);
        chk({tag, ".rd"},       r_rd, rd);
        chk({tag, ".leak"},     r_leak, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        areset = 1'b1;
        if32.req_valid = 1'b0; if32.req_store = 1'b0; if32.req_funct3 = 3'd0;
        if32.req_addr = '0; if32.req_wdata = '0; if32.req_rd = '0;
        if64.req_valid = 1'b0; if64.req_store = 1'b0; if64.req_funct3 = 3'd0;
        if64.req_addr = '0; if64.req_wdata = '0; if64.req_rd = '0;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        chk("rst32.ready", if32.req_ready, 1);
        chk("rst32.en",    if32.en_data, 0);
        chk("rst32.we",    64'(if32.we_data), 0);
        chk("rst32.resp",  if32.resp_valid, 0);
        chk("rst32.addr",  64'(if32.addr_data), 0);
        chk("rst64.ready", if64.req_ready, 1);
        chk("rst64.en",    if64.en_data, 0);
        chk("rst64.resp",  if64.resp_valid, 0);

        // 32-bit loads, mem[0x100] = 8899AABB, latency 2
        txn(0, 0, 3'd0, 64'h103, 0, 5'd3);  exp_load("lb_103",  64'h100, 64'hFFFFFF88, 4, 3);
        txn(0, 0, 3'd4, 64'h103, 0, 5'd4);  exp_load("lbu_103", 64'h100, 64'h00000088, 4, 4);
        txn(0, 0, 3'd0, 64'h100, 0, 5'd1);  exp_load("lb_100",  64'h100, 64'hFFFFFFBB, 4, 1);
        txn(0, 0, 3'd0, 64'h101, 0, 5'd2);  exp_load("lb_101",  64'h100, 64'hFFFFFFAA, 4, 2);
        txn(0, 0, 3'd4, 64'h102, 0, 5'd6);  exp_load("lbu_102", 64'h100, 64'h00000099, 4, 6);
        txn(0, 0, 3'd1, 64'h102, 0, 5'd7);  exp_load("lh_102",  64'h100, 64'hFFFF8899, 4, 7);
        txn(0, 0, 3'd5, 64'h100, 0, 5'd8);  exp_load("lhu_100", 64'h100, 64'h0000AABB, 4, 8);
        txn(0, 0, 3'd2, 64'h100, 0, 5'd0);  exp_load("lw_100",  64'h100, 64'h8899AABB, 4, 0);

        // 32-bit stores and read-back
        txn(0, 1, 3'd1, 64'h102, 64'h1234CAFE, 5'd7);
        exp_store("sh_102", 64'h100, 64'hC, 64'hCAFE0000, 7);
        txn(0, 1, 3'd0, 64'h101, 64'hABCDEF55, 5'd9);
        exp_store("sb_101", 64'h100, 64'h2, 64'hCDEF5500, 9);
        txn(0, 0, 3'd2, 64'h100, 0, 5'd10); exp_load("lw_after_st",  64'h100, 64'hCAFE55BB, 4, 10);
        txn(0, 0, 3'd5, 64'h100, 0, 5'd11); exp_load("lhu_after_st", 64'h100, 64'h000055BB, 4, 11);

        // 32-bit error paths
        txn(0, 0, 3'd2, 64'h102, 0, 5'd12); exp_err("lw_mis",   2'b01, 12);
        txn(0, 0, 3'd1, 64'h101, 0, 5'd13); exp_err("lh_mis",   2'b01, 13);
        txn(0, 0, 3'd3, 64'h100, 0, 5'd14); exp_err("ld_on32",  2'b10, 14);
        txn(0, 0, 3'd3, 64'h101, 0, 5'd15); exp_err("ld_prec",  2'b10, 15);
        txn(0, 1, 3'd4, 64'h100, 0, 5'd16); exp_err("sb_f3_4",  2'b10, 16);
        txn(0, 0, 3'd7, 64'h100, 0, 5'd17); exp_err("f3_7",     2'b10, 17);
        txn(0, 0, 3'd6, 64'h100, 0, 5'd18); exp_err("lwu_on32", 2'b10, 18);

        // Reset during WAIT of an LW drops the response
        @(negedge clk);
        if32.req_store = 1'b0; if32.req_funct3 = 3'd2; if32.req_addr = 32'h100;
        if32.req_rd = 5'd5; if32.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if32.req_valid = 1'b0;
        chk("rstw.access_en", if32.en_data, 1);
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        chk("rstw.en_in_rst",   if32.en_data, 0);
        chk("rstw.resp_in_rst", if32.resp_valid, 0);
        areset = 1'b0;
        r_resp_cnt = 0;
        @(negedge clk);
        chk("rstw.ready_after", if32.req_ready, 1);
        for (int c = 0; c < 6; c++) begin
            if (if32.resp_valid) r_resp_cnt = r_resp_cnt + 1;
            @(negedge clk);
        end
        chk("rstw.no_resp", r_resp_cnt, 0);
        txn(0, 0, 3'd2, 64'h100, 0, 5'd5); exp_load("lw_post_rst", 64'h100, 64'h8899AABB, 4, 5);

        // 64-bit build, mem[0x8] = 80000000_00000001, latency 1
        txn(1, 0, 3'd2, 64'hC, 0, 5'd9);  exp_load("lw64_c",  64'h8, 64'hFFFFFFFF_80000000, 3, 9);
        txn(1, 0, 3'd6, 64'hC, 0, 5'd10); exp_load("lwu64_c", 64'h8, 64'h00000000_80000000, 3, 10);
        txn(1, 0, 3'd3, 64'h8, 0, 5'd11); exp_load("ld64_8",  64'h8, 64'h80000000_00000001, 3, 11);
        txn(1, 0, 3'd0, 64'hF, 0, 5'd12); exp_load("lb64_f",  64'h8, 64'hFFFFFFFF_FFFFFF80, 3, 12);
        txn(1, 0, 3'd1, 64'hE, 0, 5'd13); exp_load("lh64_e",  64'h8, 64'hFFFFFFFF_FFFF8000, 3, 13);
        txn(1, 0, 3'd4, 64'h8, 0, 5'd14); exp_load("lbu64_8", 64'h8, 64'h00000000_00000001, 3, 14);
        txn(1, 0, 3'd3, 64'hFFFFFFFF_FFFFFFF8, 0, 5'd15);
        exp_load("ld64_top", 64'hFFFFFFFF_FFFFFFF8, 64'h0, 3, 15);
        txn(1, 1, 3'd2, 64'hC, 64'h11223344, 5'd16);
        exp_store("sw64_c", 64'h8, 64'hF0, 64'h11223344_00000000, 16);
        txn(1, 0, 3'd3, 64'h8, 0, 5'd17); exp_load("ld64_after_st", 64'h8, 64'h11223344_00000001, 3, 17);
        txn(1, 0, 3'd3, 64'hC, 0, 5'd18); exp_err("ld64_mis", 2'b01, 18);
        txn(1, 0, 3'd7, 64'h8, 0, 5'd19); exp_err("f3_7_64",  2'b10, 19);
        txn(1, 1, 3'd6, 64'h8, 0, 5'd20); exp_err("sw_f3_6",  2'b10, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
